// File: rtl/mem_pkg.sv
// Purpose : shared types and constants for the memory-side strobe responder.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
// Contents: FSM state enum, read/write encoding of MRW, default widths.
package mem_pkg;

    localparam int MEM_ADDR_W_DEF = 8;
    localparam int MEM_DATA_W_DEF = 32;
    localparam int MEM_WAIT_DEF   = 4;
    localparam int MEM_CTR_W      = 8;

    // MRW encoding as driven by the cache controller.
    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/resp_wait_ctr.sv
// Purpose : 8-bit loadable down-counter timing the responder wait states.
// Latency : load/decrement take effect at the next rising edge; zero flag is combinational.
// Backpr. : none; decrement saturates at zero.
// Ports   : clk, rst_n (async active-low), i_load/i_load_val, i_dec, o_zero.
module resp_wait_ctr
    import mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic [MEM_CTR_W-1:0] i_load_val,
    input  logic                 i_dec,
    output logic                 o_zero
);

    logic [MEM_CTR_W-1:0] r_cnt;

    // Load wins over decrement so a new request always starts a full count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_responder.sv
// Purpose : main-memory responder: accepts an MStrobe request, waits WAIT_CYCLES, commits, pulses MReady.
// Latency : strobe at edge k commits at edge k+WAIT_CYCLES; MReady high for the following cycle.
// Backpr. : none; strobes while busy are dropped (flagged on ProtoErr when enabled).
// Ports   : clk, reset (async active-low), MStrobe/MRW/MAddr/MDataIn in; MDataOut/MReady out;
//           ProtoErr out only when MEM_RESP_PROTOCOL_CHECK_EN is defined.
// Macro   : MEM_RESP_PROTOCOL_CHECK_EN adds the sticky busy-strobe error flag.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W_DEF,
    parameter int DATA_W      = MEM_DATA_W_DEF,
    parameter int WAIT_CYCLES = MEM_WAIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MStrobe,
    input  logic              MRW,
    input  logic [ADDR_W-1:0] MAddr,
    input  logic [DATA_W-1:0] MDataIn,
    output logic [DATA_W-1:0] MDataOut,
    output logic              MReady
`ifdef MEM_RESP_PROTOCOL_CHECK_EN
    ,
    output logic              ProtoErr
`endif
);

    // The wait counter is 8 bits wide, so only 1..255 wait states can be expressed.
    if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 255)) begin : g_wait_range_chk
        $error("mem_responder: WAIT_CYCLES=%0d outside 1..255", WAIT_CYCLES);
    end

    localparam logic [MEM_CTR_W-1:0] LP_CTR_LOAD = MEM_CTR_W'(WAIT_CYCLES - 1);

    mem_state_t          r_state;
    logic                r_rw;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_dout;
    logic                r_ready;
    logic [DATA_W-1:0]   r_mem [2**ADDR_W];

    logic                w_accept;
    logic                w_ctr_zero;
    logic                w_ctr_dec;
    logic                w_commit;

    assign w_accept  = (r_state == IDLE) && MStrobe;
    assign w_ctr_dec = (r_state == WAIT) && !w_ctr_zero;
    // Reset forces r_state to IDLE, so an access in flight can never commit under reset.
    assign w_commit  = (r_state == WAIT) && w_ctr_zero;

    resp_wait_ctr u_wait_ctr (
        .clk        (clk),
        .rst_n      (reset),
        .i_load     (w_accept),
        .i_load_val (LP_CTR_LOAD),
        .i_dec      (w_ctr_dec),
        .o_zero     (w_ctr_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_rw    <= MEM_RD;
            r_addr  <= '0;
            r_wdata <= '0;
            r_dout  <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b0;
                    if (MStrobe) begin
                        r_rw    <= MRW;
                        r_addr  <= MAddr;
                        r_wdata <= MDataIn;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_ctr_zero) begin
                        if (r_rw == MEM_RD) begin
                            r_dout <= r_mem[r_addr];
                        end
                        r_ready <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_ready <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Storage is deliberately not reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (w_commit && (r_rw == MEM_WR)) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign MDataOut = r_dout;
    assign MReady   = r_ready;

`ifdef MEM_RESP_PROTOCOL_CHECK_EN
    logic r_proto_err;

    // Sticky: any strobe seen while busy latches the error until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_proto_err <= 1'b0;
        end else if (MStrobe && (r_state != IDLE)) begin
            r_proto_err <= 1'b1;
        end
    end

    assign ProtoErr = r_proto_err;
`else
    // Without the check, strobes while busy are silently dropped by the FSM.
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Purpose : scoreboard bench for mem_responder with WAIT_CYCLES = 4, 1 and 255 instances.
// Latency : expected MReady cycle is strobe edge + WAIT_CYCLES; checked by a negedge monitor.
// Backpr. : n/a; busy-time strobes are driven on purpose and must be dropped.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              rst_n;
    logic [2:0]        strb;
    logic [2:0]        rw;
    logic [2:0]        rdy;
    logic [2:0][7:0]   addr;
    logic [2:0][31:0]  din;
    logic [2:0][31:0]  dout;
`ifdef MEM_RESP_PROTOCOL_CHECK_EN
    logic [2:0]        perr;
`endif

    typedef struct {
        int          cyc;
        logic [31:0] dout;
    } exp_t;

    exp_t        q [3][$];
    logic [31:0] mdl [3][256];
    logic [31:0] edout [3];
    int          n_checks = 0;
    int          n_fail   = 0;

    mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(4)) u_dut4 (
        .clk(clk), .reset(rst_n), .MStrobe(strb[0]), .MRW(rw[0]), .MAddr(addr[0]),
        .MDataIn(din[0]), .MDataOut(dout[0]), .MReady(rdy[0])
`ifdef MEM_RESP_PROTOCOL_CHECK_EN
        , .ProtoErr(perr[0])
`endif
    );

    mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(rst_n), .MStrobe(strb[1]), .MRW(rw[1]), .MAddr(addr[1]),
        .MDataIn(din[1]), .MDataOut(dout[1]), .MReady(rdy[1])
`ifdef MEM_RESP_PROTOCOL_CHECK_EN
        , .ProtoErr(perr[1])
`endif
    );

    mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(255)) u_dut255 (
        .clk(clk), .reset(rst_n), .MStrobe(strb[2]), .MRW(rw[2]), .MAddr(addr[2]),
        .MDataIn(din[2]), .MDataOut(dout[2]), .MReady(rdy[2])
`ifdef MEM_RESP_PROTOCOL_CHECK_EN
        , .ProtoErr(perr[2])
`endif
    );

    function automatic int wc(int i);
        case (i)
            0:       return 4;
            1:       return 1;
            default: return 255;
        endcase
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every MReady pulse must match the oldest expected entry
    // in cycle and data; an entry whose cycle passes without a pulse is a miss.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rdy[i]) begin
                if (q[i].size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ready dut%0d: MReady=1 with nothing outstanding (cycle %0d)", i, cyc);
                end else begin
                    exp_t e;
                    e = q[i].pop_front();
                    chk($sformatf("ready_cycle dut%0d", i), 32'(cyc), 32'(e.cyc));
                    chk($sformatf("dataout dut%0d", i), dout[i], e.dout);
                end
            end else if (q[i].size() != 0 && q[i][0].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_ready dut%0d: no MReady, expected at cycle %0d (now %0d)", i, q[i][0].cyc, cyc);
                void'(q[i].pop_front());
            end
        end
    end

    task automatic issue(int i, logic wr, logic [7:0] a, logic [31:0] d, bit push);
        exp_t e;
        @(negedge clk);
        strb[i] = 1'b1;
        rw[i]   = wr;
        addr[i] = a;
        din[i]  = d;
        if (push) begin
            if (wr) mdl[i][a] = d;
            else    edout[i]  = mdl[i][a];
            e.cyc  = cyc + 1 + wc(i);
            e.dout = edout[i];
            q[i].push_back(e);
        end
        @(negedge clk);
        strb[i] = 1'b0;
    endtask

    task automatic wait_idle(int i);
        int n = 0;
        while (q[i].size() != 0 && n < 700) begin
            @(negedge clk);
            n++;
        end
        if (q[i].size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout dut%0d: %0d responses outstanding", i, q[i].size());
            q[i].delete();
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outs(string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s MReady dut%0d", tag, i), 32'(rdy[i]), 32'd0);
            chk($sformatf("%s MDataOut dut%0d", tag, i), dout[i], 32'd0);
`ifdef MEM_RESP_PROTOCOL_CHECK_EN
            chk($sformatf("%s ProtoErr dut%0d", tag, i), 32'(perr[i]), 32'd0);
`endif
        end
    endtask

    initial begin
        exp_t e;
        int   k;
        rst_n = 1'b0;
        strb  = '0;
        rw    = '0;
        addr  = '0;
        din   = '0;
        for (int i = 0; i < 3; i++) edout[i] = 32'd0;

        repeat (2) @(negedge clk);
        check_reset_outs("reset_init");
        rst_n = 1'b1;

        // Basic write then read-back at WAIT_CYCLES=4.
        issue(0, 1'b1, 8'h10, 32'hDEADBEEF, 1'b1);
        wait_idle(0);
        issue(0, 1'b0, 8'h10, 32'h0, 1'b1);
        wait_idle(0);

        // Address range extremes must not alias.
        issue(0, 1'b1, 8'h00, 32'h00000001, 1'b1);
        wait_idle(0);
        issue(0, 1'b1, 8'hFF, 32'h00000002, 1'b1);
        wait_idle(0);
        issue(0, 1'b0, 8'h00, 32'h0, 1'b1);
        wait_idle(0);
        issue(0, 1'b0, 8'hFF, 32'h0, 1'b1);
        wait_idle(0);

        // A strobe while in WAIT must be dropped without touching memory.
        issue(0, 1'b1, 8'h20, 32'h12345678, 1'b1);
        wait_idle(0);
        issue(0, 1'b1, 8'h30, 32'h00003333, 1'b1);
        issue(0, 1'b1, 8'h20, 32'h0BAD0BAD, 1'b0);
        wait_idle(0);
`ifdef MEM_RESP_PROTOCOL_CHECK_EN
        chk("proto_err_set", 32'(perr[0]), 32'd1);
`endif
        issue(0, 1'b0, 8'h20, 32'h0, 1'b1);
        wait_idle(0);
        issue(0, 1'b0, 8'h30, 32'h0, 1'b1);
        wait_idle(0);

        // Reset two cycles into a write aborts it and clears the outputs.
        issue(0, 1'b1, 8'h05, 32'h00005555, 1'b1);
        wait_idle(0);
        issue(0, 1'b0, 8'h10, 32'h0, 1'b1);
        wait_idle(0);
        issue(0, 1'b1, 8'h05, 32'h0000AAAA, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outs("reset_mid");
        repeat (6) @(negedge clk);
        chk("reset_hold MReady dut0", 32'(rdy[0]), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) edout[i] = 32'd0;
        issue(0, 1'b0, 8'h05, 32'h0, 1'b1);
        wait_idle(0);

        // Continuous strobe at WAIT_CYCLES=1: back-to-back reads every 3 cycles.
        issue(1, 1'b1, 8'h07, 32'h00000077, 1'b1);
        wait_idle(1);
        @(negedge clk);
        strb[1] = 1'b1;
        rw[1]   = 1'b0;
        addr[1] = 8'h07;
        din[1]  = 32'h0;
        k = cyc + 1;
        edout[1] = mdl[1][8'h07];
        for (int j = 0; j < 3; j++) begin
            e.cyc  = k + j * 3 + 1;
            e.dout = edout[1];
            q[1].push_back(e);
        end
        while (cyc < k + 6) @(negedge clk);
        strb[1] = 1'b0;
        wait_idle(1);
        repeat (4) @(negedge clk);

        // Maximum wait-state count.
        issue(2, 1'b1, 8'h03, 32'h000000C3, 1'b1);
        wait_idle(2);
        issue(2, 1'b0, 8'h03, 32'h0, 1'b1);
        wait_idle(2);

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("queue_drained dut%0d", i), 32'(q[i].size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Main-memory responder for the cache's memory-side strobe protocol. It accepts a request pulse (`MStrobe`, `MRW`, address, write data) from the cache controller and models a fixed wait-state latency. It then commits the write or returns read data, and signals completion with a one-cycle `MReady` pulse. It sits below the cache controller and serves as the synthesizable backing store and the bench memory for cache bring-up.

## Interface
Parameters:
- `ADDR_W`, 8: word-address width; depth = 2**ADDR_W words.
- `DATA_W`, 32: word width.
- `WAIT_CYCLES`, 4: wait states per access; legal range 1..255.

Ports:
- `clk`  in  1  sole clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `MStrobe`  in  1  request pulse from the cache controller.
- `MRW`  in  1  0 = read, 1 = write; sampled with `MStrobe`.
- `MAddr`  in  ADDR_W  word address; sampled with `MStrobe`.
- `MDataIn`  in  DATA_W  write data; sampled with `MStrobe`.
- `MDataOut`  out  DATA_W  read data.
- `MReady`  out  1  one-cycle completion pulse.
- `ProtoErr`  out  1  sticky protocol-error flag; present only with the macro defined (see Configuration).

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE with `MStrobe`=1 at an edge:
  - latch `MRW`, `MAddr` and `MDataIn`;
  - load the wait counter with WAIT_CYCLES-1;
  - go to WAIT.
- IDLE with `MStrobe`=0: stay in IDLE.
- WAIT with counter ≠ 0: decrement the counter.
- WAIT with counter = 0, at the next edge:
  - write: `mem[addr]` ← latched data;
  - read: `MDataOut` ← `mem[addr]`;
  - `MReady` ← 1; go to DONE.
- DONE: `MReady` ← 0; go to IDLE. This state is always exactly one cycle.
- `MStrobe` in WAIT or DONE is ignored: the request is not queued and latched fields are not changed.
- `MDataOut` holds its value until the next read completes. Writes do not change `MDataOut`.
- The address spans the full range; there is no wrap or out-of-range case. Both `MAddr`=0 and `MAddr`=2**ADDR_W-1 are legal.
- Counter width is 8 bits. WAIT_CYCLES outside 1..255 is a static elaboration error (assertion).

## Timing
- `MStrobe` is sampled at edge k. The access commits at edge k+WAIT_CYCLES, and `MReady` is high during the cycle after that edge.
- `MReady` falls at edge k+WAIT_CYCLES+1.
- Earliest next acceptance is edge k+WAIT_CYCLES+2, with `MStrobe` held or re-asserted in IDLE.
- A strobe held high continuously therefore produces back-to-back accesses of period WAIT_CYCLES+2.
- Reset values: state IDLE, counter 0, `MReady` 0, `MDataOut` 0, `ProtoErr` 0.
- Memory array is not reset. Contents are X until written.
- Reset asserted mid-access aborts the access:
  - no write commit;
  - no `MReady` pulse;
  - `MDataOut` is cleared.
  - Reset overrides a same-cycle completion.
- Deassertion of reset is synchronous to `clk` at the integration level. The block does not add its own reset synchronizer.

## Configuration
- `MEM_RESP_PROTOCOL_CHECK_EN` defined:
  - adds the `ProtoErr` output;
  - `ProtoErr` is set at any edge where `MStrobe`=1 and state ≠ IDLE;
  - it stays set until reset;
  - functional behaviour is otherwise unchanged.
- Undefined: no `ProtoErr` port, and strobes while busy are silently ignored.

## Structure
- Shared package `mem_pkg`:
  - state enum `mem_state_t` (IDLE, WAIT, DONE);
  - `MEM_RD`=1'b0 and `MEM_WR`=1'b1 constants;
  - default width constants.
- Sub-module `resp_wait_ctr`: an 8-bit loadable down-counter with async active-low reset and a zero flag.
- Storage array and FSM stay in `mem_responder`.

## Test plan
- Write 0xDEADBEEF to addr 0x10, then read addr 0x10 with WAIT_CYCLES=4 → `MReady` high exactly 4 edges after each strobe edge, and `MDataOut`=0xDEADBEEF after the read.
- Write 0x1 to addr 0x00 and 0x2 to addr 0xFF, then read both → 0x1 and 0x2; no aliasing at the boundaries.
- Strobe a write to addr 0x20 while in WAIT → ignored; `mem[0x20]` unchanged; one `MReady` per accepted request; `ProtoErr`=1 when the macro is defined.
- Assert reset two cycles into a write of 0xAAAA to addr 0x05 → no `MReady`; a later read of 0x05 returns its prior value; all outputs are 0 during reset.
- Hold `MStrobe` high for 3 reads with WAIT_CYCLES=1 → `MReady` pulses every 3 cycles, each pulse one cycle wide.
- WAIT_CYCLES=255 single read → `MReady` exactly 255 edges after the strobe edge.
